pattern_checker: RTL and testbench

PATTERN_CHECKER -- requirements
Module: pattern_checker

---
 rtl/pattern_checker_if.sv | 35 +++
 rtl/pattern_checker.sv | 159 +++++++++++++++
 tb/tb_pattern_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_checker_if.sv
// pattern_checker_if
//   Serial receive bus of the pattern checker.
//   data_in     received serial bit (decoded HDB3 stream)
//   data_valid  qualifies data_in for one clock
//   locked      checker is in the LOCKED state
//   bit_err     one-cycle pulse per mismatching bit while locked
//   err_count   saturating count of mismatches while locked
//   frame_count wrapping count of completed pattern periods while locked
//   master: drives the data side; slave: the checker.
interface pattern_checker_if;
  logic        data_in;
  logic        data_valid;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;
  logic [15:0] frame_count;

  modport master (
    output data_in,
    output data_valid,
    input  locked,
    input  bit_err,
    input  err_count,
    input  frame_count
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output locked,
    output bit_err,
    output err_count,
    output frame_count
  );
endinterface

// File: rtl/pattern_checker.sv
// pattern_checker
//   Locks onto a repeating 33-bit test pattern (sent LSB first) in a serial
//   bit stream and counts bit errors and completed pattern periods while
//   locked. Too many errors within one pattern period drops lock and the
//   checker re-hunts using the bits already in its shift register.
//   Parameters:
//     PATTERN    33-bit test pattern, bit 0 transmitted first
//     ERR_LIMIT  errors within one period that cause loss of lock (1..33)
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   pattern_checker_if.slave (data_in/data_valid in; locked,
//           bit_err, err_count, frame_count out, all registered)
module pattern_checker #(
  parameter logic [32:0] PATTERN   = 33'h1_1C03_0C21,
  parameter int unsigned ERR_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  pattern_checker_if.slave  bus
);

  localparam logic [5:0] LAST_PHASE  = 6'd32;
  localparam logic [5:0] FILL_FULL   = 6'd33;
  localparam logic [5:0] ERR_LIMIT_W = 6'(ERR_LIMIT);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] sr_q, sr_d;
  logic [5:0]  fill_q, fill_d;
  logic [5:0]  phase_q, phase_d;
  logic [5:0]  win_q, win_d;
  logic        locked_q, locked_d;
  logic        bit_err_q, bit_err_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        hunt_hit;
  logic        bit_ok;
  logic        lose_lock;
  logic        at_last_phase;
  logic [5:0]  phase_next;

  // The window of 33 bits ending with the current bit matches PATTERN, and
  // every one of those bits arrived since reset (fill including this bit).
  assign hunt_hit      = ({bus.data_in, sr_q[32:1]} == PATTERN) &&
                         (fill_q >= LAST_PHASE);
  assign bit_ok        = (bus.data_in == PATTERN[phase_q]);
  assign at_last_phase = (phase_q == LAST_PHASE);
  assign phase_next    = at_last_phase ? '0 : phase_q + 6'd1;
  // Loss of lock counts the current bad bit toward the window total.
  assign lose_lock     = !bit_ok && ((win_q + 6'd1) == ERR_LIMIT_W);

  // State register and all registered outputs/counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      fill_q        <= '0;
      phase_q       <= '0;
      win_q         <= '0;
      locked_q      <= 1'b0;
      bit_err_q     <= 1'b0;
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      fill_q        <= fill_d;
      phase_q       <= phase_d;
      win_q         <= win_d;
      locked_q      <= locked_d;
      bit_err_q     <= bit_err_d;
      err_count_q   <= err_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.data_valid) begin
      unique case (state_q)
        HUNT: begin
          if (hunt_hit) state_d = VERIFY;
        end
        VERIFY: begin
          if (!bit_ok)            state_d = HUNT;
          else if (at_last_phase) state_d = LOCKED;
        end
        LOCKED: begin
          if (lose_lock) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output logic: locked follows the state being registered this edge so
  // the flag and the state change together.
  always_comb begin
    locked_d  = (state_d == LOCKED);
    bit_err_d = bus.data_valid && (state_q == LOCKED) && !bit_ok;
  end

  // Datapath: shift register, fill, phase and counters.
  always_comb begin
    sr_d          = sr_q;
    fill_d        = fill_q;
    phase_d       = phase_q;
    win_d         = win_q;
    err_count_d   = err_count_q;
    frame_count_d = frame_count_q;

    if (bus.data_valid) begin
      // The shift register and fill run in every state, so after a loss of
      // lock the hunt can match on the very next valid bit.
      sr_d = {bus.data_in, sr_q[32:1]};
      if (fill_q != FILL_FULL) fill_d = fill_q + 6'd1;

      unique case (state_q)
        HUNT: begin
          if (hunt_hit) begin
            phase_d = '0;
            win_d   = '0;
          end
        end
        VERIFY: begin
          phase_d = phase_next;
          win_d   = '0;
        end
        LOCKED: begin
          phase_d = phase_next;
          if (!bit_ok) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            win_d = win_q + 6'd1;
          end
          // Loss of lock wins over the period boundary: no frame credit.
          if (!lose_lock && at_last_phase) begin
            frame_count_d = frame_count_q + 16'd1;
            win_d         = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.locked      = locked_q;
  assign bus.bit_err     = bit_err_q;
  assign bus.err_count   = err_count_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_pattern_checker.sv
module tb_pattern_checker;

  localparam logic [32:0] PAT = 33'h1_1C03_0C21;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_checker_if bus ();

  pattern_checker #(
    .PATTERN  (PAT),
    .ERR_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit locked;
    bit bit_err;
    int errs;
    int frames;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: hunting looks at the last 33 received bits directly;
  // after a match, pos is the position inside the pattern of the next bit.
  int m_hist[$];
  int m_mode;     // 0 hunting, 1 verifying, 2 locked
  int m_pos;
  int m_win;
  int m_errs;
  int m_frames;
  bit m_biterr;

  int pidx;       // index of next pattern bit the stimulus sends

  task automatic model_step(input bit b, input bit v, input bit r);
    bit all_eq;
    bit bad;
    m_biterr = 1'b0;
    if (r) begin
      m_hist.delete();
      m_mode = 0; m_pos = 0; m_win = 0; m_errs = 0; m_frames = 0;
      return;
    end
    if (!v) return;
    m_hist.push_back(int'(b));
    if (m_hist.size() > 33) void'(m_hist.pop_front());
    if (m_mode == 0) begin
      all_eq = (m_hist.size() == 33);
      for (int i = 0; i < m_hist.size(); i++)
        if (m_hist[i] != int'(PAT[i])) all_eq = 1'b0;
      if (all_eq) begin
        m_mode = 1; m_pos = 0;
      end
    end else begin
      bad = (b != PAT[m_pos]);
      if (m_mode == 1) begin
        if (bad) m_mode = 0;
        else if (m_pos == 32) begin
          m_mode = 2; m_win = 0;
        end
      end else begin
        if (bad) begin
          m_biterr = 1'b1;
          if (m_errs < 65535) m_errs++;
          m_win++;
        end
        if (bad && m_win == int'(LIM)) m_mode = 0;
        else if (m_pos == 32) begin
          m_frames = (m_frames + 1) % 65536;
          m_win = 0;
        end
      end
      m_pos = (m_pos + 1) % 33;
    end
  endtask

  task automatic send(input bit b, input bit v, input bit r);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.data_valid = v;
    bus.data_in = b;
    model_step(b, v, r);
    e.locked = (m_mode == 2);
    e.bit_err = m_biterr;
    e.errs = m_errs;
    e.frames = m_frames;
    sb.push_back(e);
  endtask

  // Send n pattern bits; flip_at >= 0 inverts that bit (counted from 0).
  // toggle inserts an idle cycle before every valid bit.
  task automatic send_pat(input int n, input bit toggle, input int flip_at);
    for (int i = 0; i < n; i++) begin
      if (toggle) send(1'b1, 1'b0, 1'b0);
      send(PAT[pidx] ^ (i == flip_at), 1'b1, 1'b0);
      pidx = (pidx + 1) % 33;
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) send(1'b0, 1'b0, 1'b1);
    pidx = 0;
  endtask

  // Monitor: outputs are always presented, so compare once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.locked !== e.locked || bus.bit_err !== e.bit_err ||
            int'(bus.err_count) != e.errs || int'(bus.frame_count) != e.frames) begin
          failures++;
          $display("FAIL outputs @%0t: got locked=%0b bit_err=%0b err=%0d frames=%0d, want locked=%0b bit_err=%0b err=%0d frames=%0d",
                   $time, bus.locked, bus.bit_err, bus.err_count, bus.frame_count,
                   e.locked, e.bit_err, e.errs, e.frames);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in = 1'b0;
    pidx = 0;

    // Clean pattern from reset: lock after bit 66, frames every 33 bits.
    do_reset(2);
    send_pat(150, 1'b0, -1);
    // Single inverted bit while locked.
    send_pat(80, 1'b0, 20);
    // Four consecutive bad bits: loss of lock, then relock.
    for (int i = 0; i < 4; i++) send_pat(1, 1'b0, 0);
    send_pat(120, 1'b0, -1);

    // Stream starting at pattern bit 10.
    do_reset(1);
    pidx = 10;
    send_pat(120, 1'b0, -1);

    // Inverted bit during verify (bit 40), with valid every other cycle.
    do_reset(1);
    send_pat(39, 1'b1, -1);
    send_pat(1, 1'b1, 0);
    send_pat(150, 1'b1, -1);

    // Build err_count to 3 while locked, then a 1-cycle reset mid-lock.
    do_reset(1);
    send_pat(70, 1'b0, -1);
    for (int k = 0; k < 3; k++) send_pat(33, 1'b0, 5);
    do_reset(1);
    send_pat(80, 1'b0, -1);

    // Random valid gaps, random bit errors, occasional slips and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 2) do_reset(1);
      else if ($urandom_range(0, 9) < 3) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else if (r < 12) pidx = (pidx + 1) % 33;
      else if (r < 40) send_pat(1, 1'b0, 0);
      else send_pat(1, 1'b0, -1);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
